pipe_hazard_ctrl: RTL and testbench

- Central sequencing controller for the 16-bit 5-stage pipeline.
- Drives write enables and flushes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Produces forwarding selects for the EX operand muxes.
- Freezes the whole pipeline on data-memory wait states, and supports halt/resume with a sticky memory-timeout error.

---
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 16-bit 5-stage pipeline: register enables,
// flushes, EX forwarding selects, dmem wait-state freeze, halt/resume and timeout error.
module pipe_hazard_ctrl #(
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rs_addr,
    input  logic [3:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [3:0]  ex_rd_addr,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [3:0]  mem_rd_addr,
    input  logic        mem_reg_write,
    input  logic [3:0]  wb_rd_addr,
    input  logic        wb_reg_write,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_wen,
    output logic        ifid_wen,
    output logic        ifid_flush,
    output logic        idex_wen,
    output logic        idex_flush,
    output logic        exmem_wen,
    output logic        memwb_wen,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic        halted,
    output logic        mem_err
);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

    localparam logic [1:0]  LP_FLUSH_LOAD = 2'(BR_PENALTY - 1);
    localparam logic [16:0] LP_TIMEOUT    = 17'(MEM_TIMEOUT);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_wait_cnt, w_wait_nxt;
    logic [1:0]  r_flush_cnt, w_flush_nxt;
    logic [15:0] r_stall_cnt;
    logic        r_mem_err;

    logic        w_freeze, w_load_use, w_err_set, w_halted;
    logic        w_pc_wen, w_ifid_wen, w_idex_wen, w_exmem_wen, w_memwb_wen;
    logic        w_ifid_flush, w_idex_flush;
    logic [16:0] w_wait_inc;

    // MEM result is younger than WB, so it wins; r0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [3:0] src);
        if (mem_reg_write && mem_rd_addr == src && src != 4'd0)
            return 2'b01;
        else if (wb_reg_write && wb_rd_addr == src && src != 4'd0)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(id_rs_addr);
    assign fwd_b = fwd_sel(id_rt_addr);

    assign w_freeze   = dmem_req & ~dmem_ready;
    assign w_wait_inc = {1'b0, r_wait_cnt} + 17'd1;
    assign w_load_use = ex_mem_read & ex_reg_write & (ex_rd_addr != 4'd0) &
                        ((id_uses_rs & (id_rs_addr == ex_rd_addr)) |
                         (id_uses_rt & (id_rt_addr == ex_rd_addr)));

    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait_cnt;
        w_flush_nxt  = r_flush_cnt;
        w_err_set    = 1'b0;
        w_halted     = 1'b0;
        w_pc_wen     = 1'b1;
        w_ifid_wen   = 1'b1;
        w_idex_wen   = 1'b1;
        w_exmem_wen  = 1'b1;
        w_memwb_wen  = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;

        if (r_state == S_HALT) begin
            {w_pc_wen, w_ifid_wen, w_idex_wen, w_exmem_wen, w_memwb_wen} = 5'b00000;
            w_halted   = 1'b1;
            w_wait_nxt = 16'd0;
            if (resume && !r_mem_err && !halt_req)
                w_state_nxt = S_RUN;
        end else if (w_freeze) begin
            // A held branch/halt is simply deferred until the access completes.
            {w_pc_wen, w_ifid_wen, w_idex_wen, w_exmem_wen, w_memwb_wen} = 5'b00000;
            w_wait_nxt = w_wait_inc[15:0];
            if (w_wait_inc == LP_TIMEOUT) begin
                w_err_set   = 1'b1;
                w_state_nxt = S_HALT;
            end
        end else begin
            w_wait_nxt = 16'd0;
            if (r_state == S_FLUSH) begin
                w_ifid_flush = 1'b1;
                if (branch_taken) begin
                    w_idex_flush = 1'b1;
                    w_flush_nxt  = LP_FLUSH_LOAD;
                end else if (r_flush_cnt <= 2'd1) begin
                    w_flush_nxt = 2'd0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_flush_nxt = r_flush_cnt - 2'd1;
                end
            end else if (branch_taken) begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
                if (BR_PENALTY > 1) begin
                    w_state_nxt = S_FLUSH;
                    w_flush_nxt = LP_FLUSH_LOAD;
                end
            end else if (w_load_use) begin
                w_pc_wen     = 1'b0;
                w_ifid_wen   = 1'b0;
                w_idex_flush = 1'b1;
            end
            if (halt_req)
                w_state_nxt = S_HALT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= 16'd0;
            r_flush_cnt <= 2'd0;
            r_stall_cnt <= 16'd0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_flush_cnt <= w_flush_nxt;
            if (w_err_set)
                r_mem_err <= 1'b1;
            if (r_state != S_HALT && !w_pc_wen && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign pc_wen     = w_pc_wen;
    assign ifid_wen   = w_ifid_wen;
    assign idex_wen   = w_idex_wen;
    assign exmem_wen  = w_exmem_wen;
    assign memwb_wen  = w_memwb_wen;
    assign ifid_flush = w_ifid_flush;
    assign idex_flush = w_idex_flush;
    assign stall_cnt  = r_stall_cnt;
    assign halted     = w_halted;
    assign mem_err    = r_mem_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (BR_PENALTY=2, MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_rs_addr, id_rt_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write;
    logic        mem_reg_write, wb_reg_write, branch_taken;
    logic        dmem_req, dmem_ready, halt_req, resume;
    logic        pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, memwb_wen;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic        halted, mem_err;

    pipe_hazard_ctrl #(.BR_PENALTY(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .resume(resume),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .idex_wen(idex_wen), .idex_flush(idex_flush),
        .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt),
        .halted(halted), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {pc,ifid,idex,exmem,memwb wen, ifid_flush, idex_flush, fwd_a, fwd_b, stall_cnt, halted, mem_err}
    typedef struct {
        string       name;
        logic [28:0] vec;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [28:0] got;
            e   = q.pop_front();
            got = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush,
                   fwd_a, fwd_b, stall_cnt, halted, mem_err};
            checks++;
            if (got !== e.vec) begin
                errors++;
                $display("FAIL %s: got %b_%b%b_%b_%b_%h_%b%b required %b_%b%b_%b_%b_%h_%b%b", e.name,
                         got[28:24], got[23], got[22], got[21:20], got[19:18], got[17:2], got[1], got[0],
                         e.vec[28:24], e.vec[23], e.vec[22], e.vec[21:20], e.vec[19:18], e.vec[17:2],
                         e.vec[1], e.vec[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected response for the current cycle's inputs, then advance one cycle.
    task automatic expect_cyc(input string name, input logic [4:0] wen, input logic ifl, input logic idf,
                              input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] sc,
                              input logic h, input logic me);
        exp_t e;
        e.name = name;
        e.vec  = {wen, ifl, idf, fa, fb, sc, h, me};
        q.push_back(e);
        tick();
    endtask

    task automatic clr();
        id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rd_addr = 0; ex_mem_read = 0; ex_reg_write = 0;
        mem_rd_addr = 0; mem_reg_write = 0; wb_rd_addr = 0; wb_reg_write = 0;
        branch_taken = 0; dmem_req = 0; dmem_ready = 0; halt_req = 0; resume = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clr();
        tick();
        expect_cyc("reset", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd0, 0, 0);
        rst = 1'b1;

        // Forwarding
        mem_reg_write = 1; mem_rd_addr = 3; wb_reg_write = 1; wb_rd_addr = 3; id_rs_addr = 3;
        expect_cyc("fwd_mem_beats_wb", 5'b11111, 0, 0, 2'b01, 2'b00, 16'd0, 0, 0);
        clr(); mem_reg_write = 1; mem_rd_addr = 0; wb_reg_write = 1; wb_rd_addr = 0;
        expect_cyc("fwd_r0", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd0, 0, 0);
        clr(); wb_reg_write = 1; wb_rd_addr = 5; id_rt_addr = 5; mem_reg_write = 1; mem_rd_addr = 2; id_rs_addr = 2;
        expect_cyc("fwd_wb_b", 5'b11111, 0, 0, 2'b01, 2'b10, 16'd0, 0, 0);
        clr(); mem_reg_write = 0; mem_rd_addr = 7; wb_reg_write = 1; wb_rd_addr = 7; id_rs_addr = 7;
        expect_cyc("fwd_mem_nowrite", 5'b11111, 0, 0, 2'b10, 2'b00, 16'd0, 0, 0);

        // Load-use
        clr(); ex_mem_read = 1; ex_reg_write = 1; ex_rd_addr = 4; id_uses_rt = 1; id_rt_addr = 4;
        expect_cyc("loaduse", 5'b00111, 0, 1, 2'b00, 2'b00, 16'd0, 0, 0);
        clr();
        expect_cyc("loaduse_after", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd1, 0, 0);
        ex_mem_read = 1; ex_reg_write = 1; ex_rd_addr = 0; id_uses_rt = 1; id_rt_addr = 0;
        expect_cyc("loaduse_r0", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd1, 0, 0);

        // Branch, penalty 2
        clr(); branch_taken = 1;
        expect_cyc("br_c0", 5'b11111, 1, 1, 2'b00, 2'b00, 16'd1, 0, 0);
        branch_taken = 0;
        expect_cyc("br_c1", 5'b11111, 1, 0, 2'b00, 2'b00, 16'd1, 0, 0);
        expect_cyc("br_c2", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd1, 0, 0);
        branch_taken = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd_addr = 4; id_uses_rs = 1; id_rs_addr = 4;
        expect_cyc("br_over_loaduse", 5'b11111, 1, 1, 2'b00, 2'b00, 16'd1, 0, 0);
        clr();
        expect_cyc("br_lu_c1", 5'b11111, 1, 0, 2'b00, 2'b00, 16'd1, 0, 0);
        expect_cyc("br_lu_c2", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd1, 0, 0);

        // Wait states with a held branch
        dmem_req = 1; dmem_ready = 0; branch_taken = 1;
        expect_cyc("freeze1", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd1, 0, 0);
        expect_cyc("freeze2", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd2, 0, 0);
        expect_cyc("freeze3", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd3, 0, 0);
        dmem_ready = 1;
        expect_cyc("freeze_br", 5'b11111, 1, 1, 2'b00, 2'b00, 16'd4, 0, 0);
        clr();
        expect_cyc("freeze_br_c1", 5'b11111, 1, 0, 2'b00, 2'b00, 16'd4, 0, 0);
        expect_cyc("freeze_br_c2", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd4, 0, 0);

        // Halt / resume
        halt_req = 1;
        expect_cyc("halt_req", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd4, 0, 0);
        expect_cyc("halted", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd4, 1, 0);
        resume = 1;
        expect_cyc("resume_blocked", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd4, 1, 0);
        halt_req = 0;
        expect_cyc("resume", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd4, 1, 0);
        resume = 0;
        expect_cyc("run_again", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd4, 0, 0);

        // Timeout
        dmem_req = 1; dmem_ready = 0;
        expect_cyc("to_f1", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd4, 0, 0);
        expect_cyc("to_f2", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd5, 0, 0);
        expect_cyc("to_f3", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd6, 0, 0);
        expect_cyc("to_f4", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd7, 0, 0);
        expect_cyc("to_halt", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd8, 1, 1);
        clr(); resume = 1;
        expect_cyc("to_resume_ign", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd8, 1, 1);
        resume = 0;
        expect_cyc("to_still_halt", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd8, 1, 1);
        rst = 0;
        expect_cyc("to_rst_clear", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd0, 0, 0);
        rst = 1;

        // Reset in FLUSH and mid-freeze
        branch_taken = 1;
        expect_cyc("pre_flush", 5'b11111, 1, 1, 2'b00, 2'b00, 16'd0, 0, 0);
        branch_taken = 0; rst = 0;
        expect_cyc("rst_in_flush", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd0, 0, 0);
        rst = 1;
        expect_cyc("after_flush_rst", 5'b11111, 0, 0, 2'b00, 2'b00, 16'd0, 0, 0);
        dmem_req = 1; dmem_ready = 0;
        expect_cyc("mf1", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd0, 0, 0);
        expect_cyc("mf2", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd1, 0, 0);
        rst = 0;
        expect_cyc("rst_in_freeze", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd0, 0, 0);
        rst = 1;
        expect_cyc("rf1", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd0, 0, 0);
        expect_cyc("rf2", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd1, 0, 0);
        expect_cyc("rf3", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd2, 0, 0);
        expect_cyc("rf4", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd3, 0, 0);
        expect_cyc("rf_timeout", 5'b00000, 0, 0, 2'b00, 2'b00, 16'd4, 1, 1);
        clr();

        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
